square_grid_renderer: RTL and testbench

SQUARE_GRID_RENDERER -- requirements
Module: square_grid_renderer

---
 rtl/square_grid_renderer_pkg.sv | 45 ++++
 rtl/square_grid_renderer_tower_rom.sv | 13 +
 rtl/square_grid_renderer.sv | 139 +++++++++++++
 tb/tb_square_grid_renderer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/square_grid_renderer_pkg.sv
// Shared encodings, grid/screen geometry and the tower sprite image for the cell renderer.
package square_grid_renderer_pkg;

    typedef enum logic [1:0] {
        MODE_CURSOR = 2'd0,
        MODE_TOWER  = 2'd1,
        MODE_ERASE  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    localparam int CELL_PX   = 20;
    localparam int GRID_COLS = 8;
    localparam int GRID_ROWS = 6;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;

    localparam logic [8:0] TEX_STONE  = 9'h124;
    localparam logic [8:0] TEX_WINDOW = 9'h007;
    localparam logic [8:0] TEX_BASE   = 9'h092;

    // Row-major tower image (the tower.mif picture): battlements, body with a window, wide base.
    function automatic logic [8:0] tower_texel(input logic [8:0] addr);
        int r, c;
        logic [8:0] t;
        r = int'(addr) / CELL_PX;
        c = int'(addr) % CELL_PX;
        t = 9'h000;
        if (r <= 3) begin
            if (c >= 3 && c <= 16 && ((c - 3) / 2) % 2 == 0) t = TEX_STONE;
        end else if (r <= 16) begin
            if (c >= 5 && c <= 14)
                t = (r >= 7 && r <= 10 && c >= 9 && c <= 10) ? TEX_WINDOW : TEX_STONE;
        end else if (c >= 2 && c <= 17) begin
            t = TEX_BASE;
        end
        return t;
    endfunction

endpackage

// File: rtl/square_grid_renderer_tower_rom.sv
// 400x9 synchronous tower sprite ROM holding the tower.mif image; data valid one cycle after addr.
module tower_rom (
    input  logic       clk,
    input  logic [8:0] addr,
    output logic [8:0] data
);
    import square_grid_renderer_pkg::*;

    always_ff @(posedge clk) begin
        data <= tower_texel(addr);
    end

endmodule

// File: rtl/square_grid_renderer.sv
// Renders one 20x20 grid cell to the VGA plotter: cursor outline, tower sprite, or map restore.
module square_grid_renderer #(
    parameter int         CELL_PX       = square_grid_renderer_pkg::CELL_PX,
    parameter int         SCREEN_W      = square_grid_renderer_pkg::SCREEN_W,
    parameter logic [8:0] CURSOR_COLOUR = 9'h1C0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [3:0]  cell_x,
    input  logic [3:0]  cell_y,
    input  logic [8:0]  map_colour,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [8:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done,
    output logic [14:0] map_address
);
    import square_grid_renderer_pkg::*;

    localparam logic [4:0]  LAST_PX  = 5'(CELL_PX - 1);
    localparam logic [14:0] ROW_STEP = 15'(SCREEN_W - CELL_PX + 1);

    state_e     state_q, state_d;
    logic       accept;
    logic [1:0] vld_pipe;   // [0] pixel fetched this cycle, [1] pixel on the outputs
    mode_e      mode_q;
    logic [7:0] x0_q;
    logic [6:0] y0_q;
    logic [4:0] px, py;
    logic [8:0] idx;
    logic       mask_q;
    logic [8:0] rom_data;
    logic       border, last_pix;

    assign border   = (px == 5'd0) || (px == LAST_PX) || (py == 5'd0) || (py == LAST_PX);
    assign last_pix = (px == LAST_PX) && (py == LAST_PX);
    assign plot     = vld_pipe[1] && mask_q;

    tower_rom u_rom (
        .clk  (clk),
        .addr (idx),
        .data (rom_data)
    );

    always_ff @(posedge clk) begin
        if (resetn) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && mode != MODE_RSVD &&
                    cell_x < 4'(GRID_COLS) && cell_y < 4'(GRID_ROWS)) begin
                    accept  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            // one drain cycle after the last fetch lets the final pixel reach the outputs
            S_SCAN:   if (!vld_pipe[0]) state_d = S_FINISH;
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            vld_pipe    <= '0;
            mode_q      <= MODE_CURSOR;
            x0_q        <= '0;
            y0_q        <= '0;
            px          <= '0;
            py          <= '0;
            idx         <= '0;
            mask_q      <= 1'b0;
            x           <= '0;
            y           <= '0;
            map_address <= '0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            mask_q      <= (mode_q != MODE_CURSOR) || border;
            if (accept) begin
                mode_q      <= mode_e'(mode);
                x0_q        <= 8'(int'(cell_x) * CELL_PX);
                y0_q        <= 7'(int'(cell_y) * CELL_PX);
                map_address <= 15'((int'(cell_y) * SCREEN_W + int'(cell_x)) * CELL_PX);
                px          <= '0;
                py          <= '0;
                idx         <= '0;
                vld_pipe[0] <= 1'b1;
            end else if (vld_pipe[0]) begin
                x <= x0_q + 8'(px);
                y <= y0_q + 7'(py);
                if (last_pix) begin
                    // address stays on the last pixel so the map port is stable while idle
                    px          <= '0;
                    py          <= '0;
                    idx         <= '0;
                    vld_pipe[0] <= 1'b0;
                end else begin
                    idx <= idx + 9'd1;
                    if (px == LAST_PX) begin
                        px          <= '0;
                        py          <= py + 5'd1;
                        map_address <= map_address + ROW_STEP;
                    end else begin
                        px          <= px + 5'd1;
                        map_address <= map_address + 15'd1;
                    end
                end
            end
        end
    end

    // map memory and ROM both return data a cycle after addressing, so colour is selected from
    // their outputs in the same cycle that the registered x/y/plot appear
    always_comb begin
        colour = '0;
        if (plot) begin
            case (mode_q)
                MODE_TOWER: colour = rom_data;
                MODE_ERASE: colour = map_colour;
                default:    colour = CURSOR_COLOUR;
            endcase
        end
    end

endmodule

// File: tb/tb_square_grid_renderer.sv
// Self-checking bench: directed and random cell renders against a pixel-list reference model.
module tb_square_grid_renderer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  mode;
    logic [3:0]  cell_x, cell_y;
    logic [8:0]  map_colour;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  colour;
    logic        plot, busy, done;
    logic [14:0] map_address;

    int checks = 0;
    int errors = 0;

    logic [23:0] got[$];
    logic [23:0] exp_q[$];
    int done_cnt, done_at, busy_first, busy_last, plot_first, plot_last;
    logic [8:0] img [20][20];

    square_grid_renderer dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .mode        (mode),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .map_colour  (map_colour),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done),
        .map_address (map_address)
    );

    always #5 clk = ~clk;

    // map memory model: one-cycle read latency, content = low 9 address bits
    always @(posedge clk) map_colour <= map_address[8:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic paint_tower();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++) img[r][c] = 9'h000;
        for (int r = 0; r < 4; r++)
            for (int m = 3; m <= 15; m += 4) begin
                img[r][m]   = 9'h124;
                img[r][m+1] = 9'h124;
            end
        for (int r = 4; r <= 16; r++)
            for (int c = 5; c <= 14; c++) img[r][c] = 9'h124;
        for (int r = 7; r <= 10; r++)
            for (int c = 9; c <= 10; c++) img[r][c] = 9'h007;
        for (int r = 17; r <= 19; r++)
            for (int c = 2; c <= 17; c++) img[r][c] = 9'h092;
    endtask

    function automatic void build_exp(input int m, input int cx, input int cy);
        int xx, yy;
        logic [8:0] c;
        exp_q.delete();
        for (int py = 0; py < 20; py++)
            for (int px = 0; px < 20; px++) begin
                xx = cx * 20 + px;
                yy = cy * 20 + py;
                if (m == 0 && !(px == 0 || px == 19 || py == 0 || py == 19)) continue;
                if (m == 0)      c = 9'h1C0;
                else if (m == 1) c = img[py][px];
                else             c = 9'((yy * 160 + xx) % 512);
                exp_q.push_back({8'(xx), 7'(yy), c});
            end
    endfunction

    task automatic capture(input int ncyc, input int restart_at);
        got.delete();
        done_cnt = 0; done_at = -1; busy_first = -1; busy_last = -1;
        plot_first = -1; plot_last = -1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (plot) begin
                got.push_back({x, y, colour});
                if (plot_first < 0) plot_first = i;
                plot_last = i;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = i;
                busy_last = i;
            end
            if (i == 1) start = 1'b0;
            if (i == restart_at) begin
                start = 1'b1; mode = 2'd2; cell_x = 4'd1; cell_y = 4'd1;
            end
            if (i == restart_at + 1) start = 1'b0;
        end
    endtask

    task automatic render(input string tag, input int m, input int cx, input int cy,
                          input int restart_at);
        int n;
        build_exp(m, cx, cy);
        @(negedge clk);
        mode = 2'(m); cell_x = 4'(cx); cell_y = 4'(cy); start = 1'b1;
        capture(410, restart_at);
        chk({tag, " plots"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s pix%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        chk({tag, " done_cnt"},   done_cnt,   1);
        chk({tag, " done_at"},    done_at,    402);
        chk({tag, " busy_first"}, busy_first, 1);
        chk({tag, " busy_last"},  busy_last,  402);
        chk({tag, " plot_first"}, plot_first, 2);
        chk({tag, " plot_last"},  plot_last,  401);
        chk({tag, " last_addr"},  32'(map_address), (cy * 20 + 19) * 160 + cx * 20 + 19);
    endtask

    task automatic reject(input string tag, input int m, input int cx, input int cy);
        @(negedge clk);
        mode = 2'(m); cell_x = 4'(cx); cell_y = 4'(cy); start = 1'b1;
        capture(20, 0);
        chk({tag, " plots"},    got.size(), 0);
        chk({tag, " done_cnt"}, done_cnt,   0);
        chk({tag, " busy"},     busy_first, -1);
    endtask

    initial begin
        int found;
        paint_tower();
        resetn = 1'b1; start = 1'b0; mode = 2'd0; cell_x = 4'd0; cell_y = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst x", 32'(x), 0);
        chk("rst y", 32'(y), 0);
        chk("rst colour", 32'(colour), 0);
        chk("rst plot", 32'(plot), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst addr", 32'(map_address), 0);
        resetn = 1'b0;

        render("cursor00", 0, 0, 0, 0);
        found = 0;
        foreach (got[i]) if (got[i][23:16] == 8'd5 && got[i][15:9] == 7'd5) found++;
        chk("cursor00 p55", found, 0);
        render("erase75", 2, 7, 5, 0);
        chk("erase75 addr19199", 32'(map_address), 19199);
        render("tower32", 1, 3, 2, 0);

        reject("cx8", 0, 8, 0);
        reject("mode3", 3, 2, 2);
        reject("cy6", 1, 0, 6);

        render("restart", 1, 4, 1, 100);

        // reset while pixel 200 is in flight
        @(negedge clk);
        mode = 2'd1; cell_x = 4'd2; cell_y = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("midrst x", 32'(x), 0);
        chk("midrst y", 32'(y), 0);
        chk("midrst colour", 32'(colour), 0);
        chk("midrst plot", 32'(plot), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        chk("midrst addr", 32'(map_address), 0);
        resetn = 1'b0;
        capture(420, 0);
        chk("midrst done_cnt", done_cnt, 0);
        chk("midrst plots", got.size(), 0);
        render("after_rst", 0, 6, 4, 0);

        for (int r = 0; r < 4; r++) begin
            int m, cx, cy;
            m  = int'($urandom_range(2, 0));
            cx = int'($urandom_range(7, 0));
            cy = int'($urandom_range(5, 0));
            render($sformatf("rnd%0d_m%0d_%0d_%0d", r, m, cx, cy), m, cx, cy, 0);
        end
        reject("rnd_cx", int'($urandom_range(2, 0)), int'($urandom_range(15, 8)), 0);
        reject("rnd_m3", 3, int'($urandom_range(7, 0)), int'($urandom_range(5, 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
